bitmap_scan_driver: RTL and testbench

BITMAP_SCAN_DRIVER -- requirements
Module: bitmap_scan_driver

---
 rtl/led_panel_pkg.sv | 25 ++
 rtl/panel_shift_reg.sv | 35 +++
 rtl/bitmap_scan_driver.sv | 203 ++++++++++++++++++++
 tb/tb_bitmap_scan_driver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared constants, FSM state type and row-sequencing helper for the LED panel scan driver.
package led_panel_pkg;

    localparam int PIXELS   = 64;
    localparam int BPP      = 3;
    localparam int ROWS     = 7;
    localparam int ROW_BITS = PIXELS * BPP;

    localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);
    localparam logic [5:0] LAST_PIX  = 6'(PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DISPLAY,
        NEXT
    } scan_state_e;

    function automatic logic [2:0] next_row(input logic [2:0] row);
        return (row == LAST_ROW) ? 3'd0 : row + 3'd1;
    endfunction

endpackage

// File: rtl/panel_shift_reg.sv
// 192-bit parallel-load shift register; shifts one 3-bit pixel per step, top pixel first.
module panel_shift_reg
    import led_panel_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift,
    input  logic [ROW_BITS-1:0] load_data,
    output logic [BPP-1:0]      pixel
);

    logic [ROW_BITS-1:0] sr_q, sr_d;

    // Zeros fill from the bottom so a fully shifted row leaves the data lines low.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = {sr_q[ROW_BITS-BPP-1:0], {BPP{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign pixel = sr_q[ROW_BITS-1 -: BPP];

endmodule

// File: rtl/bitmap_scan_driver.sv
// Seven-row, 64-pixel RGB LED panel scan driver: shift, latch, display, advance row.
// Optional tear-free frame buffering is enabled with `define BITMAP_SCAN_DOUBLE_BUFFER_EN.
module bitmap_scan_driver
    import led_panel_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned ON_TIME = 64
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [ROW_BITS-1:0] bitmap0,
    input  logic [ROW_BITS-1:0] bitmap1,
    input  logic [ROW_BITS-1:0] bitmap2,
    input  logic [ROW_BITS-1:0] bitmap3,
    input  logic [ROW_BITS-1:0] bitmap4,
    input  logic [ROW_BITS-1:0] bitmap5,
    input  logic [ROW_BITS-1:0] bitmap6,
    output logic                panel_r,
    output logic                panel_g,
    output logic                panel_b,
    output logic                panel_sclk,
    output logic                panel_lat,
    output logic                panel_oe_n,
    output logic [2:0]          row_addr,
    output logic                frame_done
);

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] ON_LAST  = 16'(ON_TIME - 1);

    scan_state_e         state_q, state_d;
    logic [2:0]          pend_q, pend_d;
    logic [7:0]          div_cnt_q, div_cnt_d;
    logic [5:0]          pix_cnt_q, pix_cnt_d;
    logic [15:0]         on_cnt_q, on_cnt_d;
    logic                sclk_q, sclk_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic [2:0]          row_addr_q, row_addr_d;
    logic                frame_done_q, frame_done_d;
    logic                sr_load, sr_shift;
    logic [ROW_BITS-1:0] load_data;
    logic [BPP-1:0]      pixel;
    logic [ROW_BITS-1:0] live_rows [ROWS];

    assign live_rows[0] = bitmap0;
    assign live_rows[1] = bitmap1;
    assign live_rows[2] = bitmap2;
    assign live_rows[3] = bitmap3;
    assign live_rows[4] = bitmap4;
    assign live_rows[5] = bitmap5;
    assign live_rows[6] = bitmap6;

`ifdef BITMAP_SCAN_DOUBLE_BUFFER_EN
    logic [ROW_BITS-1:0] shadow_q [ROWS];
    logic [ROW_BITS-1:0] shadow_d [ROWS];

    // Row 0 loads straight from the live input while the whole frame is snapshotted.
    always_comb begin
        shadow_d = shadow_q;
        if (state_q == LOAD && pend_q == 3'd0) begin
            shadow_d = live_rows;
        end
        load_data = (pend_q == 3'd0) ? live_rows[0] : shadow_q[pend_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    always_comb begin
        load_data = live_rows[pend_q];
    end
`endif

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        div_cnt_d    = div_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        on_cnt_d     = on_cnt_q;
        sclk_d       = sclk_q;
        row_addr_d   = row_addr_q;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_load   = 1'b1;
                pix_cnt_d = LAST_PIX;
                div_cnt_d = '0;
                sclk_d    = 1'b0;
                state_d   = SHIFT;
            end
            // Each pixel: CLK_DIV cycles low, CLK_DIV high; data moves only on the falling step.
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d   = 1'b0;
                        sr_shift = 1'b1;
                        if (pix_cnt_q == '0) begin
                            state_d = LATCH;
                        end else begin
                            pix_cnt_d = pix_cnt_q - 6'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            LATCH: begin
                on_cnt_d = '0;
                state_d  = DISPLAY;
            end
            DISPLAY: begin
                if (on_cnt_q == ON_LAST) begin
                    state_d = NEXT;
                end else begin
                    on_cnt_d = on_cnt_q + 16'd1;
                end
            end
            NEXT: begin
                pend_d = next_row(pend_q);
                if (pend_q == LAST_ROW) begin
                    state_d = en ? LOAD : IDLE;
                end else begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        lat_d        = (state_d == LATCH);
        oe_n_d       = (state_d != DISPLAY);
        frame_done_d = (state_d == NEXT) && (pend_q == LAST_ROW);
        if (state_d == LATCH) begin
            row_addr_d = pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            div_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            on_cnt_q     <= '0;
            sclk_q       <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            div_cnt_q    <= div_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            on_cnt_q     <= on_cnt_d;
            sclk_q       <= sclk_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            row_addr_q   <= row_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    panel_shift_reg u_shift_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (load_data),
        .pixel     (pixel)
    );

    assign panel_r    = pixel[2];
    assign panel_g    = pixel[1];
    assign panel_b    = pixel[0];
    assign panel_sclk = sclk_q;
    assign panel_lat  = lat_q;
    assign panel_oe_n = oe_n_q;
    assign row_addr   = row_addr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bitmap_scan_driver.sv
// Scoreboard bench for bitmap_scan_driver: random frames, serial capture, timing and reset checks.
module tb_bitmap_scan_driver;

    localparam int CLK_DIV = 2;
    localparam int ON_TIME = 5;
    localparam int RP      = 1 + 128 * CLK_DIV + 1 + ON_TIME + 1;

    typedef struct {
        int           row;
        logic [191:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [191:0] bm [7];
    logic         panel_r, panel_g, panel_b, panel_sclk, panel_lat, panel_oe_n;
    logic [2:0]   row_addr;
    logic         frame_done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   latches  = 0;

    bitmap_scan_driver #(.CLK_DIV(CLK_DIV), .ON_TIME(ON_TIME)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bitmap0    (bm[0]),
        .bitmap1    (bm[1]),
        .bitmap2    (bm[2]),
        .bitmap3    (bm[3]),
        .bitmap4    (bm[4]),
        .bitmap5    (bm[5]),
        .bitmap6    (bm[6]),
        .panel_r    (panel_r),
        .panel_g    (panel_g),
        .panel_b    (panel_b),
        .panel_sclk (panel_sclk),
        .panel_lat  (panel_lat),
        .panel_oe_n (panel_oe_n),
        .row_addr   (row_addr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [191:0] got, input logic [191:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rgb"},        {panel_r, panel_g, panel_b}, 3'b000);
        check_output({tag, "_sclk"},       panel_sclk, 1'b0);
        check_output({tag, "_lat"},        panel_lat, 1'b0);
        check_output({tag, "_oe_n"},       panel_oe_n, 1'b1);
        check_output({tag, "_row_addr"},   row_addr, 3'd0);
        check_output({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    // Monitor: reassembles each shifted row and pops the scoreboard on every latch pulse.
    logic         prev_sclk, prev_lat, prev_fd;
    logic [2:0]   prev_rgb;
    logic [191:0] got_row;
    int           rises, oe_low_run, last_latch_row, last_latch_cyc, row6_latch_cyc;

    always @(negedge clk) begin
        logic [2:0] rgb;
        exp_t       e;
        if (!rst_n) begin
            prev_sclk      = 1'b0;
            prev_lat       = 1'b0;
            prev_fd        = 1'b0;
            prev_rgb       = 3'b000;
            got_row        = '0;
            rises          = 0;
            oe_low_run     = 0;
            last_latch_row = -1;
            last_latch_cyc = 0;
            row6_latch_cyc = -1000000;
        end else begin
            rgb = {panel_r, panel_g, panel_b};
            if (panel_sclk && !prev_sclk) begin
                check_output("data_stable_at_sclk_rise", rgb, prev_rgb);
                got_row = {got_row[188:0], rgb};
                rises++;
            end
            if (!panel_oe_n) begin
                oe_low_run++;
                check_output("quiet_during_display", {panel_lat, panel_sclk}, 2'b00);
            end else if (oe_low_run != 0) begin
                check_output("display_length", oe_low_run, ON_TIME);
                oe_low_run = 0;
            end
            if (panel_lat) begin
                latches++;
                check_output("lat_single_cycle", prev_lat, 1'b0);
                check_output("oe_n_at_latch", panel_oe_n, 1'b1);
                check_output("pixels_per_row", rises, 64);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_latch: row_addr %0d latched, no row expected", row_addr);
                end else begin
                    e = exp_q.pop_front();
                    check_output("latched_row_addr", row_addr, e.row);
                    check_output("row_pixels", got_row, e.data);
                    if (e.row > 0 && last_latch_row == e.row - 1) begin
                        check_output("row_period", cyc - last_latch_cyc, RP);
                    end
                    last_latch_row = e.row;
                    if (e.row == 6) row6_latch_cyc = cyc;
                end
                last_latch_cyc = cyc;
                rises   = 0;
                got_row = '0;
            end
            if (frame_done) begin
                check_output("frame_done_single", prev_fd, 1'b0);
                check_output("frame_done_after_row6", cyc - row6_latch_cyc, ON_TIME + 1);
            end
            prev_sclk = panel_sclk;
            prev_lat  = panel_lat;
            prev_fd   = frame_done;
            prev_rgb  = rgb;
        end
    end

    function automatic logic [191:0] rand_row();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_row(input int row, input logic [191:0] data);
        exp_t e;
        e.row  = row;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_frame_done(output int t);
        t = -1;
        for (int i = 0; i < 8 * RP; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL frame_done_timeout: no pulse within %0d cycles", 8 * RP);
        end
    endtask

    // One frame: the next DUT cycle must be the LOAD of row 0 (or IDLE sampling en).
    task automatic apply_stimulus(input bit special, input bit drop_en, output int t_done);
        logic [191:0] old5;
        for (int r = 0; r < 7; r++) bm[r] = special ? '0 : rand_row();
        if (special) bm[0][191:189] = 3'b100;
        for (int r = 0; r < 5; r++) push_row(r, bm[r]);
        old5 = bm[5];
        en = 1'b1;
        repeat (1 + 2 * RP + 10) @(posedge clk);
        #1;
        bm[5] = rand_row();
`ifdef BITMAP_SCAN_DOUBLE_BUFFER_EN
        push_row(5, old5);
`else
        push_row(5, bm[5]);
`endif
        push_row(6, bm[6]);
        if (drop_en) begin
            repeat (2 * RP) @(posedge clk);
            #1;
            en = 1'b0;
        end
        wait_frame_done(t_done);
    endtask

    initial begin
        int t1, t2, t3, t4, snap;
        rst_n = 1'b0;
        en    = 1'b0;
        for (int r = 0; r < 7; r++) bm[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("idle_en_low");

        apply_stimulus(1'b1, 1'b0, t1);
        apply_stimulus(1'b0, 1'b0, t2);
        check_output("frame_period", t2 - t1, 7 * RP);
        apply_stimulus(1'b0, 1'b1, t3);
        check_output("frame_period_en_drop", t3 - t2, 7 * RP);

        repeat (2) @(posedge clk);
        #1;
        check_output("idle_oe_n", panel_oe_n, 1'b1);
        check_output("idle_sclk", panel_sclk, 1'b0);
        check_output("idle_lat", panel_lat, 1'b0);
        snap = latches;
        repeat (2 * RP) @(posedge clk);
        #1;
        check_output("stays_idle", latches, snap);
        check_output("queue_drained_after_drop", exp_q.size(), 0);

        // Abort partway through row 3 shifting.
        for (int r = 0; r < 7; r++) bm[r] = rand_row();
        for (int r = 0; r < 3; r++) push_row(r, bm[r]);
        en = 1'b1;
        repeat (1 + 3 * RP + 50) @(posedge clk);
        #1;
        check_output("rows_before_abort", exp_q.size(), 0);
        check_output("shifting_before_abort", panel_oe_n, 1'b1);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, t4);
        repeat (2) @(posedge clk);
        #1;
        check_output("queue_drained_final", exp_q.size(), 0);
        check_output("final_oe_n", panel_oe_n, 1'b1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
